wb_arbiter_rr: RTL
==================

WB_ARBITER_RR -- requirements
Module: wb_arbiter_rr

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter N_MASTERS, default 4, SHALL set the number of requesting masters (2..16).
REQ-003 Parameter TIMEOUT_CYCLES, default 256, SHALL set the watchdog limit in clock cycles (2..65535).
REQ-004 Derived width MID_BITS SHALL be $clog2(N_MASTERS).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  N_MASTERS  per-master request (CYC & STB & address hit for this slave port).
REQ-008 cyc  input  N_MASTERS  per-master CYC, used to hold ownership.
REQ-009 done  input  1  slave ACK or ERR completing the current beat.
REQ-010 gnt  output  N_MASTERS  one-hot grant; drives the slave-side mux select.
REQ-011 gnt_id  output  MID_BITS  binary index of the granted master.
REQ-012 gnt_vld  output  1  high when any grant is held.
REQ-013 tmo_err  output  1  one-cycle pulse when the watchdog expires; routed to the timed-out master as ERR.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT and TMO; all outputs SHALL be registered.
REQ-015 In IDLE with req != 0, the block SHALL enter GRANT on the next edge, setting gnt, gnt_id and gnt_vld together (1-cycle request-to-grant latency).
REQ-016 Selection SHALL be round-robin: the first set req bit searching upward from ptr, wrapping from N_MASTERS-1 to 0.
REQ-017 ptr SHALL update to (granted index + 1) mod N_MASTERS when a grant is issued.
REQ-018 In GRANT, the grant SHALL be held while cyc[gnt_id]=1, regardless of other requests and of req[gnt_id] (bus lock across bursts and STB gaps).
REQ-019 In GRANT, cyc[gnt_id]=0 SHALL clear gnt/gnt_vld on the next edge and move to IDLE; this leaves exactly one dead cycle between tenures.
REQ-020 gnt_id SHALL hold its last value while gnt_vld=0.
REQ-021 In IDLE with req=0, outputs and ptr SHALL remain unchanged.
REQ-022 The watchdog counter SHALL clear on entry to GRANT and on any cycle with done=1.
REQ-023 The watchdog counter SHALL otherwise increment each GRANT cycle and saturate at TIMEOUT_CYCLES.
REQ-024 When the count reaches TIMEOUT_CYCLES-1 with done=0, the next edge SHALL enter TMO, clear gnt/gnt_vld and pulse tmo_err for exactly one cycle.
REQ-025 TMO SHALL stay until cyc[old gnt_id]=0, then go to IDLE; other masters SHALL NOT be granted while in TMO.
REQ-026 done=1 on the expiry cycle SHALL take priority: no timeout and the counter clears.
REQ-027 done while gnt_vld=0 SHALL be ignored.

Reset
REQ-028 rst=1 SHALL force state IDLE, gnt=0, gnt_id=0, gnt_vld=0, tmo_err=0, ptr=0 and counter=0 on the next edge, including mid-tenure and mid-TMO.
REQ-029 The first arbitration after reset SHALL start its search at master 0.

Configuration
REQ-030 Macro WB_ARBITER_TIMEOUT_EN defined: the watchdog, TMO state and tmo_err SHALL be implemented as in REQ-022..REQ-026.
REQ-031 Macro WB_ARBITER_TIMEOUT_EN undefined: there SHALL be no counter and no TMO state, tmo_err SHALL be tied to 0, and grants SHALL be held indefinitely while cyc is high.

Verification
REQ-032 Reset then req=4'b1010: gnt=4'b0010 and gnt_id=1 one cycle later; cyc[1] drops, then one dead cycle, then gnt=4'b1000.
REQ-033 All four req/cyc held high, each tenure 3 cycles: grant order SHALL be 0,1,2,3,0.
REQ-034 Master 2 granted, req[2] low with cyc[2] high for 5 cycles while req[0]=1: gnt SHALL stay 4'b0100 throughout.
REQ-035 TIMEOUT_CYCLES=8, master 1 granted with done=0: tmo_err pulses 8 cycles after the grant, gnt=0 until cyc[1] falls, then master 2 is granted if requesting.
REQ-036 TIMEOUT_CYCLES=8, done pulsed every 6 cycles: tmo_err SHALL never assert.
REQ-037 rst asserted mid-tenure of master 3: next cycle gnt=0 and gnt_vld=0; after release with req=4'b1111, master 0 is granted.

Source files
------------

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: round-robin arbiter granting one of N_MASTERS Wishbone
// masters access to a shared slave port. The grant is locked for as long
// as the owner keeps CYC high. There is one dead cycle between tenures.
//
// Optional feature: define WB_ARBITER_TIMEOUT_EN to build a watchdog. The
// watchdog revokes a grant whose slave never completes a beat. It pulses
// tmo_err for one cycle and then parks in TMO until the stuck master drops
// CYC. Without the macro, grants are held indefinitely and tmo_err is 0.
module wb_arbiter_rr #(
  parameter  int N_MASTERS      = 4,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int MID_BITS       = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] cyc,
  input  logic                 done,
  output logic [N_MASTERS-1:0] gnt,
  output logic [MID_BITS-1:0]  gnt_id,
  output logic                 gnt_vld,
  output logic                 tmo_err
);

`ifdef WB_ARBITER_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TMO} state_e;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`else
  typedef enum logic {S_IDLE, S_GRANT} state_e;
`endif

  state_e                 state_q, state_d;
  logic [N_MASTERS-1:0]   gnt_q, gnt_d;
  logic [MID_BITS-1:0]    gnt_id_q, gnt_id_d;
  logic                   gnt_vld_q, gnt_vld_d;
  logic [MID_BITS-1:0]    ptr_q, ptr_d;
  logic                   sel_vld;
  logic [MID_BITS-1:0]    sel_idx;
  logic [MID_BITS-1:0]    sel_next;
  logic                   own_cyc;

`ifdef WB_ARBITER_TIMEOUT_EN
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tmo_err_q, tmo_err_d;
`else
  // done only matters to the watchdog; it is deliberately left unused here.
  logic                   unused_done;
  assign unused_done = done;
`endif

  // CYC of the current (or, in TMO, the most recent) owner. gnt_id keeps
  // its value after the grant is dropped, so it also tracks the stuck master.
  assign own_cyc = cyc[gnt_id_q];

  // Round-robin search: the first requester at or above ptr, wrapping at N.
  // The scan runs from the farthest candidate down to ptr, so the nearest
  // candidate overwrites the others and wins.
  always_comb begin : rr_search
    logic [MID_BITS:0] idx;
    // NOTE: every variable written here gets a default first. Otherwise a
    // path that skips the assignment would infer a latch.
    sel_vld = 1'b0;
    sel_idx = '0;
    idx     = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (MID_BITS + 1)'(k);
      if (idx >= (MID_BITS + 1)'(N_MASTERS)) begin
        idx = idx - (MID_BITS + 1)'(N_MASTERS);
      end
      if (req[idx]) begin
        sel_vld = 1'b1;
        sel_idx = idx[MID_BITS-1:0];
      end
    end
  end

  // Pointer value after granting sel_idx: one past the winner, with wrap.
  assign sel_next = (sel_idx == MID_BITS'(N_MASTERS - 1)) ? '0 : sel_idx + 1'b1;

  // Next-state logic for the arbitration FSM and its registered outputs.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    gnt_vld_d = gnt_vld_q;
    ptr_d     = ptr_q;
`ifdef WB_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
    tmo_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          state_d   = S_GRANT;
          gnt_d     = {{(N_MASTERS-1){1'b0}}, 1'b1} << sel_idx;
          gnt_id_d  = sel_idx;
          gnt_vld_d = 1'b1;
          ptr_d     = sel_next;
`ifdef WB_ARBITER_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      S_GRANT: begin
        // The owner releasing CYC ends the tenure. This takes precedence
        // over a watchdog expiry in the same cycle: the master is leaving anyway.
        if (!own_cyc) begin
          state_d   = S_IDLE;
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
        end
`ifdef WB_ARBITER_TIMEOUT_EN
        else if (!done && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_TMO;
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          tmo_err_d = 1'b1;
        end else if (done) begin
          cnt_d = '0;
        end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
`ifdef WB_ARBITER_TIMEOUT_EN
      S_TMO: begin
        // Nobody else is granted until the timed-out master gives up CYC.
        if (!own_cyc) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values, whatever the statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      ptr_q     <= '0;
`ifdef WB_ARBITER_TIMEOUT_EN
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
      ptr_q     <= ptr_d;
`ifdef WB_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;
`ifdef WB_ARBITER_TIMEOUT_EN
  assign tmo_err = tmo_err_q;
`else
  assign tmo_err = 1'b0;
`endif

endmodule
